pipelined_dual_port_ram: RTL and testbench

Single-clock simple dual-port RAM (one write port, one read port) with per-byte write enables. Adds a configurable read pipeline depth with a read-valid strobe and a selectable read-during-write policy. An optional hardware clear sweep on reset replaces mandatory init-file loading. Used as a generic on-chip buffer behind stream/DMA blocks that need deterministic contents after reset and a timing-closable read path.

---
 rtl/pipelined_dual_port_ram.sv | 159 +++++++++++++++
 tb/tb_pipelined_dual_port_ram.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_dual_port_ram.sv
// Simple dual-port RAM with byte enables, pipelined read path,
// selectable read-during-write policy and optional clear sweep.
module pipelined_dual_port_ram #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    RD_LATENCY     = 1,
  parameter string                 RDW_MODE       = "read_first",
  parameter string                 CLEAR_ON_RESET = "true",
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_valid_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  output logic                    ready_o,
  output logic                    busy_o
);

  localparam int BYTE_VALID_WIDTH = DATA_WIDTH / 8;
  localparam int MEM_DEPTH        = 2 ** ADDR_WIDTH;
  localparam bit WR_FIRST         = (RDW_MODE == "write_first");
  localparam bit DO_CLEAR         = (CLEAR_ON_RESET == "true");

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_dw
    $fatal(1, "DATA_WIDTH must be a positive multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $fatal(1, "RD_LATENCY must be in 1..4");
  end
  if (RDW_MODE != "read_first" && RDW_MODE != "write_first") begin : g_bad_rdw
    $fatal(1, "RDW_MODE must be read_first or write_first");
  end
  if (CLEAR_ON_RESET != "true" && CLEAR_ON_RESET != "false") begin : g_bad_clr
    $fatal(1, "CLEAR_ON_RESET must be true or false");
  end

  typedef enum logic [1:0] {
    S_RESET,
    S_CLEAR,
    S_RUN
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic                    ready_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   pd_q  [RD_LATENCY];
  logic [RD_LATENCY-1:0]   pv_q;

  logic                    wr_acc;
  logic                    rd_acc;
  logic                    clr_we;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Reset has priority: nothing is written or launched on a reset edge.
  assign wr_acc = ready_q & wr_en_i & ~rst_i;
  assign rd_acc = ready_q & rd_en_i & ~rst_i;
  assign clr_we = (state_q == S_CLEAR) & ~rst_i;

  // Control FSM: reset hold, clear sweep, then normal operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= DO_CLEAR;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (DO_CLEAR) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_RESET;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: sweep word during clear, byte-masked writes in run.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= CLEAR_VALUE;
    end else if (wr_acc) begin
      for (int i = 0; i < BYTE_VALID_WIDTH; i++) begin
        if (wr_byte_valid_i[i]) begin
          mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // Read word with optional same-address write bypass.
  always_comb begin
    rd_word = mem_q[rd_addr_i];
    if (WR_FIRST && wr_acc && (wr_addr_i == rd_addr_i)) begin
      for (int i = 0; i < BYTE_VALID_WIDTH; i++) begin
        if (wr_byte_valid_i[i]) begin
          rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: data moves only with its valid bit, so the last
  // stage holds the most recent result between strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) begin
        pd_q[0] <= rd_word;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
        end
      end
    end
  end

  assign rd_valid_o = pv_q[RD_LATENCY-1];
  assign rd_data_o  = pd_q[RD_LATENCY-1];
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_pipelined_dual_port_ram.sv
// Bench for pipelined_dual_port_ram: two configurations driven in
// lockstep, a queue-based reference model plus directed vectors.
module tb_pipelined_dual_port_ram;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [3:0]  wr_addr;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic        a_busy, b_busy;

  pipelined_dual_port_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(3),
    .RDW_MODE("read_first"), .CLEAR_ON_RESET("true"),
    .CLEAR_VALUE(32'hDEADBEEF)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_data_i(wr_data),
    .wr_byte_valid_i(wr_be), .wr_addr_i(wr_addr),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(a_data), .rd_valid_o(a_valid),
    .ready_o(a_ready), .busy_o(a_busy)
  );

  pipelined_dual_port_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2),
    .RDW_MODE("write_first"), .CLEAR_ON_RESET("true"),
    .CLEAR_VALUE(32'h0)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_data_i(wr_data),
    .wr_byte_valid_i(wr_be), .wr_addr_i(wr_addr),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(b_data), .rd_valid_o(b_valid),
    .ready_o(b_ready), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: per instance memory, readiness and a queue of
  // pending results tagged with the edge on which they must appear.
  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  int          lat [2] = '{3, 2};
  bit          wf  [2] = '{1'b0, 1'b1};
  logic [31:0] cv  [2] = '{32'hDEADBEEF, 32'h0};

  logic [31:0] mm [2][16];
  rsp_t        mq [2][$];
  bit          m_ready [2];
  bit          m_busy  [2];
  int          m_sweep [2];
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          edge_n = 0;

  bit          any_v;
  bit          cap_v [2];
  logic [31:0] cap_d [2];

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) m = m | (32'hFF << (8 * k));
    end
    return m;
  endfunction

  task automatic model_edge(input int i);
    logic [31:0] v;
    logic [31:0] mk;
    m_valid[i] = 1'b0;
    if (rst) begin
      m_ready[i] = 1'b0;
      m_busy[i]  = 1'b1;
      m_sweep[i] = -1;
      mq[i].delete();
      m_data[i]  = 32'h0;
      return;
    end
    if (m_ready[i]) begin
      mk = be_mask(wr_be);
      if (rd_en) begin
        v = mm[i][rd_addr];
        if (wf[i] && wr_en && wr_addr == rd_addr)
          v = (v & ~mk) | (wr_data & mk);
        mq[i].push_back('{due: edge_n + lat[i] - 1, d: v});
      end
      if (wr_en)
        mm[i][wr_addr] = (mm[i][wr_addr] & ~mk) | (wr_data & mk);
    end else if (m_sweep[i] < 0) begin
      m_sweep[i] = 0;
    end else begin
      mm[i][m_sweep[i]] = cv[i];
      m_sweep[i]++;
      if (m_sweep[i] == 16) begin
        m_ready[i] = 1'b1;
        m_busy[i]  = 1'b0;
      end
    end
    if (mq[i].size() > 0 && mq[i][0].due == edge_n) begin
      m_valid[i] = 1'b1;
      m_data[i]  = mq[i][0].d;
      void'(mq[i].pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    edge_n++;
    #1;
    chk("A.valid", 32'(a_valid), 32'(m_valid[0]));
    chk("A.data",  a_data,       m_data[0]);
    chk("A.ready", 32'(a_ready), 32'(m_ready[0]));
    chk("A.busy",  32'(a_busy),  32'(m_busy[0]));
    chk("B.valid", 32'(b_valid), 32'(m_valid[1]));
    chk("B.data",  b_data,       m_data[1]);
    chk("B.ready", 32'(b_ready), 32'(m_ready[1]));
    chk("B.busy",  32'(b_busy),  32'(m_busy[1]));
    if (a_valid || b_valid) any_v = 1'b1;
    if (a_valid) begin cap_v[0] = 1'b1; cap_d[0] = a_data; end
    if (b_valid) begin cap_v[1] = 1'b1; cap_d[1] = b_data; end
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Counts busy samples from the release edge; both sweeps last 16.
  task automatic wait_clear(input string nm);
    int ca, cb;
    ca = 0;
    cb = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (!a_busy && !b_busy) break;
    end
    chk({nm, ".lenA"}, ca, 16);
    chk({nm, ".lenB"}, cb, 16);
    chk({nm, ".rdyA"}, 32'(a_ready), 1);
    chk({nm, ".rdyB"}, 32'(b_ready), 1);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{0, 0, 0,            4'h0, 1, 2,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 0, 0,            4'h0, 1, 0,  32'hDEADBEEF, 32'h0};
    tbl[2]  = '{0, 0, 0,            4'h0, 1, 15, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{1, 3, 32'hAABBCCDD, 4'h5, 0, 0,  0,            0};
    tbl[4]  = '{0, 0, 0,            4'h0, 1, 3,  32'hDEBBBEDD, 32'h00BB00DD};
    tbl[5]  = '{1, 3, 32'h11223344, 4'h0, 0, 0,  0,            0};
    tbl[6]  = '{0, 0, 0,            4'h0, 1, 3,  32'hDEBBBEDD, 32'h00BB00DD};
    tbl[7]  = '{1, 5, 32'h11111111, 4'hF, 0, 0,  0,            0};
    tbl[8]  = '{1, 5, 32'h22222222, 4'hF, 1, 5,  32'h11111111, 32'h22222222};
    tbl[9]  = '{1, 5, 32'h11111111, 4'hF, 0, 0,  0,            0};
    tbl[10] = '{1, 5, 32'h22222222, 4'h3, 1, 5,  32'h11111111, 32'h11112222};
    tbl[11] = '{0, 0, 0,            4'h0, 1, 5,  32'h11112222, 32'h11112222};
    tbl[12] = '{1, 7, 32'hCAFEF00D, 4'hF, 1, 8,  32'hDEADBEEF, 32'h0};
    tbl[13] = '{0, 0, 0,            4'h0, 1, 7,  32'hCAFEF00D, 32'hCAFEF00D};

    rst = 1'b1;
    wr_data = '0;
    wr_be = '0;
    wr_addr = '0;
    rd_addr = '0;
    idle();
    any_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 1'b0;
      m_busy[i]  = 1'b1;
      m_sweep[i] = -1;
      m_valid[i] = 1'b0;
      m_data[i]  = 32'h0;
      cap_v[i]   = 1'b0;
      cap_d[i]   = 32'h0;
    end

    // Power-up reset and first sweep.
    repeat (3) step();
    rst = 1'b0;
    wait_clear("clr1");

    // Read every word back to back.
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1;
      rd_addr = 4'(a);
      step();
    end
    idle();
    repeat (4) step();

    // Reset at clear counter 7 with requests pending during the sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h55; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    any_v = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    repeat (2) begin
      step();
      chk("midrst.busyA", 32'(a_busy), 1);
      chk("midrst.busyB", 32'(b_busy), 1);
    end
    rst = 1'b0;
    wait_clear("clr2");
    idle();
    repeat (4) step();
    chk("sweep.noval", 32'(any_v), 0);

    // Read in flight when reset hits is discarded.
    rd_en = 1'b1;
    rd_addr = 4'd1;
    step();
    idle();
    rst = 1'b1;
    any_v = 1'b0;
    step();
    chk("flush.validB", 32'(b_valid), 0);
    chk("flush.dataB", b_data, 0);
    chk("flush.dataA", a_data, 0);
    step();
    rst = 1'b0;
    wait_clear("clr3");
    chk("flush.noval", 32'(any_v), 0);

    // Directed vectors.
    for (int t = 0; t < 14; t++) begin
      cap_v[0] = 1'b0;
      cap_v[1] = 1'b0;
      wr_en = tbl[t].we; wr_addr = tbl[t].wa;
      wr_data = tbl[t].wd; wr_be = tbl[t].be;
      rd_en = tbl[t].re; rd_addr = tbl[t].ra;
      step();
      idle();
      repeat (4) step();
      chk($sformatf("tbl%0d.vA", t), 32'(cap_v[0]), 32'(tbl[t].re));
      chk($sformatf("tbl%0d.vB", t), 32'(cap_v[1]), 32'(tbl[t].re));
      if (tbl[t].re) begin
        chk($sformatf("tbl%0d.dA", t), cap_d[0], tbl[t].ea);
        chk($sformatf("tbl%0d.dB", t), cap_d[1], tbl[t].eb);
      end
    end

    // Back-to-back reads: A returns two edges after issue, B one.
    wr_be = 4'hF;
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 32'h10 + 32'(a);
      step();
    end
    idle();
    repeat (2) step();
    for (int k = 0; k < 10; k++) begin
      rd_en = (k < 4);
      rd_addr = 4'(k);
      step();
      chk($sformatf("b2b%0d.vA", k), 32'(a_valid), 32'(k >= 2 && k <= 5));
      chk($sformatf("b2b%0d.vB", k), 32'(b_valid), 32'(k >= 1 && k <= 4));
      if (k >= 2 && k <= 5)
        chk($sformatf("b2b%0d.dA", k), a_data, 32'h10 + 32'(k - 2));
      if (k >= 1 && k <= 4)
        chk($sformatf("b2b%0d.dB", k), b_data, 32'h10 + 32'(k - 1));
    end
    chk("b2b.holdA", a_data, 32'h13);
    chk("b2b.holdB", b_data, 32'h13);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr
                                            : 4'($urandom_range(0, 15));
      step();
    end
    idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
